// File: rtl/bp_me_mem_cmd_rr_arbiter.sv
// Round-robin arbiter sharing one BedRock memory command/response port between num_req_p requesters.
// Optional per-requester grant counters are built when BP_ME_MEM_ARB_STATS_EN is defined.
module bp_me_mem_cmd_rr_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 64,
    parameter int max_outstanding_p = 4,
    parameter int lg_num_req_lp     = $clog2(num_req_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_ready_o,
    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_yumi_i,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             error_o,
    output logic [num_req_p*16-1:0]          grant_count_o
);

    localparam int lg_fifo_lp = $clog2(max_outstanding_p);
    localparam logic [lg_num_req_lp-1:0] last_req_lp = lg_num_req_lp'(num_req_p - 1);
    localparam logic [lg_fifo_lp:0]      depth_lp    = (lg_fifo_lp + 1)'(max_outstanding_p);

    logic [lg_num_req_lp-1:0] rr_ptr_q, lock_id_q, rr_grant, grant, head_tag;
    logic                     lock_v_q, error_q;
    logic [lg_num_req_lp-1:0] tags_q [max_outstanding_p];
    logic [lg_fifo_lp-1:0]    head_q, tail_q;
    logic [lg_fifo_lp:0]      count_q;
    logic                     fifo_empty, fifo_full, any_v, resp_v, push, pop, found;
    int                       idx;

    always_comb begin
        rr_grant = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(rr_ptr_q) + i) % num_req_p;
            if (!found && req_cmd_v_i[idx]) begin
                rr_grant = lg_num_req_lp'(idx);
                found    = 1'b1;
            end
        end
    end

    // A stalled command keeps its owner so the downstream payload stays stable.
    assign grant      = lock_v_q ? lock_id_q : rr_grant;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == depth_lp);
    assign head_tag   = tags_q[head_q];
    assign any_v      = |req_cmd_v_i;

    assign resp_v          = mem_resp_v_i & ~fifo_empty & ~reset_i;
    assign pop             = resp_v & req_resp_yumi_i[head_tag];
    assign mem_resp_yumi_o = pop;
    assign req_resp_o      = mem_resp_i;

    // A full tag FIFO can still take a command when a response retires in the same cycle.
    assign mem_cmd_v_o = any_v & (~fifo_full | pop) & ~reset_i;
    assign push        = mem_cmd_v_o & mem_cmd_ready_i;
    assign mem_cmd_o   = req_cmd_i[grant*msg_width_p +: msg_width_p];
    assign error_o     = error_q;

    always_comb begin
        req_cmd_ready_o = '0;
        req_resp_v_o    = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant == lg_num_req_lp'(i))    req_cmd_ready_o[i] = push;
            if (head_tag == lg_num_req_lp'(i)) req_resp_v_o[i]    = resp_v;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q  <= '0;
            lock_v_q  <= 1'b0;
            lock_id_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr_q <= (grant == last_req_lp) ? '0 : grant + 1'b1;
                lock_v_q <= 1'b0;
            end else if (mem_cmd_v_o) begin
                lock_v_q  <= 1'b1;
                lock_id_q <= grant;
            end
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (mem_resp_v_i && fifo_empty) error_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tags_q[tail_q] <= grant;
    end

`ifdef BP_ME_MEM_ARB_STATS_EN
    logic [num_req_p-1:0][15:0] grant_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (push && grant == lg_num_req_lp'(i) && grant_cnt_q[i] != 16'hFFFF)
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
        end
    end

    assign grant_count_o = grant_cnt_q;
`else
    assign grant_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_rr_arbiter.sv
// Bench for bp_me_mem_cmd_rr_arbiter: directed vector table, async-reset corner and a
// randomized run against a queue-based reference model.
module tb_bp_me_mem_cmd_rr_arbiter;
    localparam int N = 2;
    localparam int W = 64;
    localparam int D = 4;
    localparam logic [W-1:0] DAT0 = 64'hA0A0_0000_0000_00A0;
    localparam logic [W-1:0] DAT1 = 64'hB1B1_1111_1111_11B1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] req_cmd;
    logic [N-1:0]   req_v, req_ready, resp_v, yumi;
    logic [W-1:0]   resp, mem_cmd, mem_resp;
    logic           mem_cmd_v, mem_rdy, mem_resp_v, mem_yumi, err;
    logic [N*16-1:0] gcnt;

    int errors = 0;
    int checks = 0;

    bp_me_mem_cmd_rr_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(D)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_cmd_i(req_cmd), .req_cmd_v_i(req_v), .req_cmd_ready_o(req_ready),
        .req_resp_o(resp), .req_resp_v_o(resp_v), .req_resp_yumi_i(yumi),
        .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_rdy),
        .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_yumi),
        .error_o(err), .grant_count_o(gcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] v; logic rdy; logic rv; logic [1:0] y;
        logic e_cmdv; int e_sel; logic [1:0] e_ready; logic [1:0] e_respv; logic e_yumi; logic e_err;
    } vec_t;
    vec_t vecs[25];

    function automatic vec_t mk(logic [1:0] v, logic rdy, logic rv, logic [1:0] y, logic cv,
                                int sel, logic [1:0] rd, logic [1:0] rsv, logic yu, logic e);
        vec_t t;
        t.v = v; t.rdy = rdy; t.rv = rv; t.y = y; t.e_cmdv = cv; t.e_sel = sel;
        t.e_ready = rd; t.e_respv = rsv; t.e_yumi = yu; t.e_err = e;
        return t;
    endfunction

    // Reference model: in-order queue of owners, scan pointer and a held owner (-1 = none).
    int  mq[$];
    int  m_rr, m_lock;
    bit  m_err;
    logic         ex_cmdv, ex_push, ex_pop, ex_yumi, ex_empty;
    int           ex_grant;
    logic [N-1:0] ex_ready, ex_respv;

    function automatic void model_clear();
        mq.delete(); m_rr = 0; m_lock = -1; m_err = 0;
    endfunction

    function automatic void model_eval();
        int g = -1;
        if (m_lock >= 0) g = m_lock;
        else for (int k = 0; k < N; k++) if (g < 0 && req_v[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g < 0) g = m_rr;
        ex_grant = g;
        ex_empty = (mq.size() == 0);
        ex_pop   = mem_resp_v && !ex_empty && yumi[mq[0]];
        ex_cmdv  = (req_v != 0) && (mq.size() < D || ex_pop);
        ex_push  = ex_cmdv && mem_rdy;
        ex_ready = ex_push ? (N'(1) << g) : '0;
        ex_respv = (mem_resp_v && !ex_empty) ? (N'(1) << mq[0]) : '0;
        ex_yumi  = ex_pop;
    endfunction

    function automatic void model_commit();
        if (mem_resp_v && ex_empty) m_err = 1;
        if (ex_pop) void'(mq.pop_front());
        if (ex_push) begin
            mq.push_back(ex_grant);
            m_rr   = (ex_grant + 1) % N;
            m_lock = -1;
        end else if (ex_cmdv) begin
            m_lock = ex_grant;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_v = '0; mem_rdy = 1'b0; mem_resp_v = 1'b0; yumi = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    logic [N-1:0] pend;
    logic [W-1:0] dat [N];

    initial begin
        req_cmd = {DAT1, DAT0}; mem_resp = '0;
        vecs[0]  = mk(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
        vecs[1]  = mk(2'b11, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
        vecs[2]  = mk(2'b11, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
        vecs[3]  = mk(2'b00, 1, 1, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vecs[4]  = mk(2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 2'b10, 0, 0);
        vecs[5]  = mk(2'b00, 1, 1, 2'b10, 0, 0, 2'b00, 2'b10, 1, 0);
        vecs[6]  = mk(2'b00, 1, 1, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vecs[7]  = mk(2'b10, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
        vecs[8]  = mk(2'b00, 1, 1, 2'b10, 0, 0, 2'b00, 2'b10, 1, 0);
        vecs[9]  = mk(2'b10, 0, 0, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0);
        vecs[10] = mk(2'b11, 0, 0, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0);
        vecs[11] = mk(2'b11, 0, 0, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0);
        vecs[12] = mk(2'b11, 1, 0, 2'b00, 1, 1, 2'b10, 2'b00, 0, 0);
        vecs[13] = mk(2'b01, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
        vecs[14] = mk(2'b01, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
        vecs[15] = mk(2'b01, 1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0);
        vecs[16] = mk(2'b01, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vecs[17] = mk(2'b01, 1, 1, 2'b10, 1, 0, 2'b01, 2'b10, 1, 0);
        vecs[18] = mk(2'b01, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 19; i < 23; i++) vecs[i] = mk(2'b00, 1, 1, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vecs[23] = mk(2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0);
        vecs[24] = mk(2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1);

        do_reset();
        @(negedge clk);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_cmd_v", {63'd0, mem_cmd_v}, 64'd0);
        chk("reset_gcnt", {32'd0, gcnt}, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            req_v = vecs[i].v; mem_rdy = vecs[i].rdy; mem_resp_v = vecs[i].rv; yumi = vecs[i].y;
            mem_resp = 64'hC0DE_0000_0000_0000 | 64'(i);
            @(negedge clk);
            chk($sformatf("vec%0d_cmd_v", i), {63'd0, mem_cmd_v}, {63'd0, vecs[i].e_cmdv});
            chk($sformatf("vec%0d_ready", i), {62'd0, req_ready}, {62'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d_resp_v", i), {62'd0, resp_v}, {62'd0, vecs[i].e_respv});
            chk($sformatf("vec%0d_mem_yumi", i), {63'd0, mem_yumi}, {63'd0, vecs[i].e_yumi});
            chk($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, vecs[i].e_err});
            chk($sformatf("vec%0d_resp", i), resp, 64'hC0DE_0000_0000_0000 | 64'(i));
            if (vecs[i].e_cmdv)
                chk($sformatf("vec%0d_mem_cmd", i), mem_cmd, (vecs[i].e_sel == 0) ? DAT0 : DAT1);
            @(posedge clk); #1;
        end

        // Asynchronous reset pulse in the middle of a cycle with traffic present.
        req_v = 2'b11; mem_rdy = 1'b0; mem_resp_v = 1'b1; yumi = 2'b11;
        #2 rst = 1'b1;
        #1;
        chk("midrst_err", {63'd0, err}, 64'd0);
        chk("midrst_cmd_v", {63'd0, mem_cmd_v}, 64'd0);
        chk("midrst_ready", {62'd0, req_ready}, 64'd0);
        chk("midrst_resp_v", {62'd0, resp_v}, 64'd0);
        chk("midrst_yumi", {63'd0, mem_yumi}, 64'd0);
        mem_resp_v = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        mem_resp_v = 1'b1;
        @(negedge clk);
        chk("postrst_empty_resp_v", {62'd0, resp_v}, 64'd0);
        chk("postrst_empty_yumi", {63'd0, mem_yumi}, 64'd0);
        chk("postrst_rr_cmd", mem_cmd, DAT0);
        chk("postrst_cmd_v", {63'd0, mem_cmd_v}, 64'd1);
        @(posedge clk); #1;
        mem_resp_v = 1'b0;
        @(negedge clk);
        chk("spurious_err_set", {63'd0, err}, 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        pend = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    dat[i]  = {$urandom, $urandom};
                end
                req_cmd[i*W +: W] = dat[i];
            end
            req_v      = pend;
            mem_rdy    = ($urandom_range(3, 0) != 0);
            mem_resp_v = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
            yumi       = N'($urandom);
            mem_resp   = {$urandom, $urandom};
            @(negedge clk);
            model_eval();
            chk("rnd_cmd_v", {63'd0, mem_cmd_v}, {63'd0, ex_cmdv});
            chk("rnd_ready", {62'd0, req_ready}, {62'd0, ex_ready});
            chk("rnd_resp_v", {62'd0, resp_v}, {62'd0, ex_respv});
            chk("rnd_mem_yumi", {63'd0, mem_yumi}, {63'd0, ex_yumi});
            chk("rnd_err", {63'd0, err}, {63'd0, m_err});
            chk("rnd_resp", resp, mem_resp);
            if (ex_cmdv) chk("rnd_mem_cmd", mem_cmd, dat[ex_grant]);
            if (ex_push) pend[ex_grant] = 1'b0;
            model_commit();
            @(posedge clk); #1;
        end

`ifdef BP_ME_MEM_ARB_STATS_EN
        do_reset();
        req_v = 2'b01; mem_rdy = 1'b1;
        @(posedge clk); #1;
        mem_resp_v = 1'b1; yumi = 2'b01;
        repeat (70000) @(posedge clk);
        #1 req_v = '0; mem_resp_v = 1'b0;
        @(negedge clk);
        chk("stats_sat0", {48'd0, gcnt[15:0]}, 64'h0000_0000_0000_FFFF);
        chk("stats_lane1", {48'd0, gcnt[31:16]}, 64'd0);
`else
        @(negedge clk);
        chk("stats_off", {32'd0, gcnt}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_me_mem_cmd_rr_arbiter.md
# bp_me_mem_cmd_rr_arbiter

Round-robin arbiter that shares one BedRock memory command/response port between `num_req_p` cache-side requesters: the UCE/CCE instances of a multi-cache dcache test subsystem, in front of `bp_mem`. Commands are granted fairly, and the winning requester index is recorded in an in-order tag FIFO. Memory responses are steered back to the recorded requester. The block makes `num_caches_p > 1` configurations share a single memory model without changing the memory side.

## Interface
Parameters:
- `num_req_p`, 2, number of requesters (≥2)
- `msg_width_p`, 64, width of one packed `bp_bedrock_cce_mem_msg_s`
- `max_outstanding_p`, 4, tag FIFO depth (power of 2)
- `lg_num_req_lp`, derived `$clog2(num_req_p)`

Ports:
- `clk_i` in 1: clock
- `reset_i` in 1: reset, asynchronous, active-high
- `req_cmd_i` in `num_req_p*msg_width_p`: per-requester command
- `req_cmd_v_i` in `num_req_p`: command valid
- `req_cmd_ready_o` out `num_req_p`: command accepted (one-hot or zero)
- `req_resp_o` out `msg_width_p`: response, broadcast to all requesters
- `req_resp_v_o` out `num_req_p`: response valid, one-hot to the owner
- `req_resp_yumi_i` in `num_req_p`: response consumed
- `mem_cmd_o` out `msg_width_p`; `mem_cmd_v_o` out 1; `mem_cmd_ready_i` in 1
- `mem_resp_i` in `msg_width_p`; `mem_resp_v_i` in 1; `mem_resp_yumi_o` out 1
- `error_o` out 1: sticky protocol error
- `grant_count_o` out `num_req_p*16`: per-requester grant counters (see Configuration)

## Operation
- State:
  - `rr_ptr` (lg bits)
  - `lock_v` and `lock_id`
  - tag FIFO: `max_outstanding_p` entries × lg bits, with head/tail pointers and a count
  - `error_o`
- Grant selection:
  - If `lock_v`, grant = `lock_id`.
  - Otherwise, grant = the first index with `req_cmd_v_i` set, scanning from `rr_ptr` upward modulo `num_req_p`.
- Command path:
  - `mem_cmd_v_o` = any valid and FIFO not full.
  - `mem_cmd_o` = `req_cmd_i[grant]`.
  - `req_cmd_ready_o[grant]` = `mem_cmd_v_o` & `mem_cmd_ready_i`.
- On a command handshake:
  - push grant into the tag FIFO
  - `rr_ptr` ← grant+1, wrapping `num_req_p`-1 → 0
  - `lock_v` ← 0
- If `mem_cmd_v_o` & !`mem_cmd_ready_i`: `lock_v` ← 1 and `lock_id` ← grant. The downstream command must not change while valid.
- Response path:
  - head = FIFO head tag.
  - `req_resp_v_o[head]` = `mem_resp_v_i` & FIFO non-empty.
  - `req_resp_o` = `mem_resp_i`.
  - `mem_resp_yumi_o` = `req_resp_yumi_i[head]` & `req_resp_v_o[head]`; pop on yumi.
- Memory returns responses in command order; the block relies on this and does no reordering.
- `mem_resp_v_i` while the FIFO is empty sets `error_o`. The response is not yumi'd, and `error_o` holds until reset.
- Requesters must hold `req_cmd_v_i` and data until ready. Withdrawing a locked request is illegal; the block keeps presenting `lock_id`.

## Timing
- Command and response paths are combinational, 0-cycle latency.
- `rr_ptr`, lock and FIFO update on the rising edge after a handshake.
- Push and pop in the same cycle are allowed:
  - count unchanged
  - when full, a push is allowed only if the same cycle pops (ready depends on pop)
- FIFO full → `mem_cmd_v_o` = 0, all `req_cmd_ready_o` = 0.
- Reset (asynchronous, at any time including mid-transfer):
  - `rr_ptr` = 0, `lock_v` = 0, FIFO empty, `error_o` = 0, counters = 0
  - while `reset_i` is high, `mem_cmd_v_o`, `req_cmd_ready_o`, `req_resp_v_o` and `mem_resp_yumi_o` are forced 0
  - in-flight tags are discarded; memory must also be reset
- Fairness: a continuously valid requester is granted within `num_req_p` handshakes.

## Configuration
- `BP_ME_MEM_ARB_STATS_EN` defined:
  - each `grant_count_o` lane is a 16-bit counter, incremented on that requester's command handshake
  - saturates at 16'hFFFF
  - reset to 0
- Not defined: `grant_count_o` tied to 0 and no counter flops. Arbitration behaviour is identical either way.

## Test plan
- **Both requesters continuously valid, `mem_cmd_ready_i`=1**: grants alternate 0,1,0,1; `rr_ptr` toggles every cycle; FIFO holds tags in the same order.
- **Backpressure lock**: req1 valid, `mem_cmd_ready_i`=0 for 3 cycles, req0 raises valid in cycle 2 → `mem_cmd_o` stays `req_cmd_i[1]`. Req1 is accepted when ready rises; req0 is accepted next.
- **Fill 4 outstanding commands with no responses**: 5th command sees `mem_cmd_v_o`=0. Returning one response (yumi) in the same cycle as the 5th command → command accepted, count stays 4.
- **Responses for tags 1,0,1**: `req_resp_v_o` = 2'b10, 2'b01, 2'b10 in order. Withholding `req_resp_yumi_i` stalls `mem_resp_yumi_o` at 0.
- **Spurious `mem_resp_v_i` with empty FIFO**: `error_o`=1 the next cycle and stays 1; async `reset_i` pulse mid-cycle → `error_o`=0, FIFO empty, outputs 0 immediately.
- **With `BP_ME_MEM_ARB_STATS_EN`**: 70000 grants to req0 → `grant_count_o[0]` = 16'hFFFF. Without the macro, all lanes are 0.
